// File: rtl/mult_div_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the divide-by-zero LO pattern.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } md_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// One step of an unsigned restoring divider: shifts the next dividend bit into
// the partial remainder and emits one quotient bit.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    always_comb begin
        part  = {rem_i, quo_i[WIDTH-1]};
        diff  = part - {1'b0, dvs_i};
        rem_o = rem_i;
        quo_o = quo_i;
        if (en_i) begin
            // A borrow out of the subtraction means the divisor did not fit.
            if (!diff[WIDTH]) begin
                rem_o = diff[WIDTH-1:0];
                quo_o = {quo_i[WIDTH-2:0], 1'b1};
            end else begin
                rem_o = part[WIDTH-1:0];
                quo_o = {quo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULT_DIV_FAST_MULT_EN for a single-cycle combinational multiply.
import mult_div_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic             rsign_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    logic             sgn_op;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             last_step;

    assign sgn_op    = op_is_signed(op);
    assign mag1      = (sgn_op && input1[WIDTH-1]) ? -input1 : input1;
    assign mag2      = (sgn_op && input2[WIDTH-1]) ? -input2 : input2;
    assign last_step = (cnt_q == CNT_W'(WIDTH-1));

`ifdef MULT_DIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] ext1;
    logic [2*WIDTH-1:0] ext2;
    logic [2*WIDTH-1:0] fast_prod;

    // Extending both operands to 2*WIDTH lets one truncated multiply serve
    // both signed and unsigned forms.
    assign ext1      = sgn_op ? {{WIDTH{input1[WIDTH-1]}}, input1} : {{WIDTH{1'b0}}, input1};
    assign ext2      = sgn_op ? {{WIDTH{input2[WIDTH-1]}}, input2} : {{WIDTH{1'b0}}, input2};
    assign fast_prod = ext1 * ext2;
`else
    logic               is_div_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     acc_sum;

    // Upper half accumulates the multiplicand; lower half holds the
    // multiplier and is consumed one bit per cycle as everything shifts right.
    assign acc_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign acc_d   = {acc_sum, acc_q[WIDTH-1:1]};
`endif

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .en_i  (state_q == DIV),
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
`ifndef MULT_DIV_FAST_MULT_EN
            is_div_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE already reports busy=0, so it accepts work like IDLE.
                IDLE, DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        dbz_q   <= 1'b0;
                        cnt_q   <= '0;
                        sign_q  <= sgn_op & (input1[WIDTH-1] ^ input2[WIDTH-1]);
                        rsign_q <= sgn_op & input1[WIDTH-1];
                        if (op_is_div(op)) begin
                            if (input2 == '0) begin
                                hi_q    <= input1;
                                lo_q    <= WIDTH'(DIV0_LO);
                                dbz_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                rem_q   <= '0;
                                quo_q   <= mag1;
                                dvs_q   <= mag2;
                                busy_q  <= 1'b1;
                                state_q <= DIV;
`ifndef MULT_DIV_FAST_MULT_EN
                                is_div_q <= 1'b1;
`endif
                            end
                        end else begin
`ifdef MULT_DIV_FAST_MULT_EN
                            {hi_q, lo_q} <= fast_prod;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
`else
                            acc_q    <= {{WIDTH{1'b0}}, mag2};
                            mcand_q  <= mag1;
                            is_div_q <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= MUL;
`endif
                        end
                    end else begin
                        if (mthi) hi_q <= input1;
                        if (mtlo) lo_q <= input1;
                    end
                end
`ifndef MULT_DIV_FAST_MULT_EN
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end
                end
`endif
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end
                end
                FIX: begin
`ifdef MULT_DIV_FAST_MULT_EN
                    lo_q <= sign_q  ? -quo_q : quo_q;
                    hi_q <= rsign_q ? -rem_q : rem_q;
`else
                    if (is_div_q) begin
                        lo_q <= sign_q  ? -quo_q : quo_q;
                        hi_q <= rsign_q ? -rem_q : rem_q;
                    end else begin
                        {hi_q, lo_q} <= sign_q ? -acc_q : acc_q;
                    end
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit: an arithmetic reference model checked
// every cycle, plus directed cases with hand-computed results.
import mult_div_pkg::*;

module tb_mult_div_unit;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam bit FAST    = 1'b1;
    localparam int MUL_LAT = 1;
`else
    localparam bit FAST    = 1'b0;
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .input1      (input1),
        .input2      (input2),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one op, straight from integer arithmetic.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output bit z);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        z  = 1'b0;
        h  = '0;
        l  = '0;
        if (o[1] && b == 32'h0) begin
            z = 1'b1;
            h = a;
            l = 32'hFFFFFFFF;
        end else begin
            case (o)
                OP_MULT:  begin q  = sa * sb; h = q[63:32];  l = q[31:0];  end
                OP_MULTU: begin uq = ua * ub; h = uq[63:32]; l = uq[31:0]; end
                OP_DIV:   begin q  = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
                default:  begin uq = ua / ub; ur = ua % ub; l = uq[31:0]; h = ur[31:0]; end
            endcase
        end
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
    bit          m_busy = 0, m_done = 0, m_dbz = 0, z0;
    int          wait_cyc = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dbz = 0; wait_cyc = 0;
        end else begin
            m_done = 0;
            if (wait_cyc > 0) begin
                wait_cyc--;
                if (wait_cyc == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1; m_busy = 0;
                end
            end else if (start) begin
                ref_op(op, input1, input2, p_hi, p_lo, z0);
                m_dbz = z0;
                if (z0 || (!op[1] && FAST)) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1;
                end else begin
                    wait_cyc = 33;
                    m_busy   = 1;
                end
            end else begin
                if (mthi) m_hi = input1;
                if (mtlo) m_lo = input1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model busy", {31'b0, busy}, {31'b0, m_busy});
            check("model done", {31'b0, done}, {31'b0, m_done});
            check("model div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
            check("model hi", hi, m_hi);
            check("model lo", lo, m_lo);
        end
    end

    // Leaves the caller at the negedge of cycle 1 (first cycle after accept).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; input1 = a; input2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int cyc0, input int lat, input int busy_exp);
        int cyc = cyc0;
        int bcnt = 0;
        while (!done && cyc < 80) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, cyc, lat);
        check({nm, " busy cycles"}, bcnt, busy_exp);
    endtask

    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el, input logic ez);
        issue(o, a, b);
        wait_done(nm, 1, lat, lat - 1);
        check({nm, " hi"}, hi, eh);
        check({nm, " lo"}, lo, el);
        check({nm, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, ez});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset div_by_zero", {31'b0, div_by_zero}, 32'h0);

        do_op("MULTU max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("MULT -7*3", OP_MULT, 32'hFFFFFFF9, 32'd3, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        do_op("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);
        do_op("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0, 32'h80000000, 1'b0);
        do_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1'b1);
        do_op("MULTU 2*3", OP_MULTU, 32'd2, 32'd3, MUL_LAT, 32'd0, 32'd6, 1'b0);

        @(negedge clk);
        mthi = 1'b1; input1 = 32'hA5A5A5A5;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi idle", hi, 32'hA5A5A5A5);

        issue(OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        mtlo = 1'b1; input1 = 32'hDEADBEEF;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo busy", lo, 32'd6);
        wait_done("DIVU after mtlo", 3, DIV_LAT, DIV_LAT - 3);
        check("DIVU after mtlo lo", lo, 32'd14);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort busy", {31'b0, busy}, 32'h0);
        begin
            int pulses = 0;
            repeat (40) begin
                if (done) pulses++;
                @(negedge clk);
            end
            check("abort done pulses", pulses, 0);
        end

`ifndef MULT_DIV_FAST_MULT_EN
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIVU; input1 = 32'd9; input2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("MULT restart ignored", 6, MUL_LAT, MUL_LAT - 6);
        check("MULT restart hi", hi, 32'd0);
        check("MULT restart lo", lo, 32'd42);
`endif

        repeat (6000) begin
            @(negedge clk);
            reset  = ($urandom_range(0, 599) == 0);
            start  = ($urandom_range(0, 3) == 0);
            op     = 2'($urandom_range(0, 3));
            input1 = pick();
            input2 = pick();
            mthi   = ($urandom_range(0, 5) == 0);
            mtlo   = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit sitting in the execute stage beside the ALU.
- Consumes the same operands `input1` and `input2` (rs, rt) and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Results are held in architectural HI/LO registers that feed the MFHI/MFLO writeback path.
- Raises `busy` so the control unit can stall dependent MFHI/MFLO and new mult/div instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only when busy=0.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- input1  input  WIDTH  rs operand (multiplicand or dividend).
- input2  input  WIDTH  rt operand (multiplier or divisor).
- mthi  input  1  write `input1` into HI.
- mtlo  input  1  write `input1` into LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an op.
- div_by_zero  output  1  sticky flag, set by DIV/DIVU with input2=0; cleared by the next accepted start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
  - Reset overrides every other input, including mid-operation: the op is aborted and no done pulse is produced.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start=1 latches op and operands.
  - Signed ops (MULT, DIV) latch operand magnitudes and record result signs: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - Next state is MUL for op[1]=0, otherwise DIV. busy=1 from the cycle after start.
- DIV with input2=0:
  - Goes directly to DONE.
  - Result: hi=input1, lo=32'hFFFFFFFF, div_by_zero=1.
- MUL:
  - Shift-add radix-2, one multiplier bit per cycle, 64-bit accumulator.
  - Runs exactly WIDTH cycles, then goes to FIX.
- DIV:
  - Restoring divide, one quotient bit per cycle.
  - Runs exactly WIDTH cycles, then goes to FIX.
- FIX:
  - Applies two's-complement negation per the recorded signs.
  - Product: hi = upper word, lo = lower word.
  - Divide: lo = quotient, hi = remainder.
  - Next state is DONE.
- DONE:
  - HI/LO are written on entry.
  - done=1 for exactly one cycle, busy=0 in the same cycle; next state is IDLE.
- Latency: start accepted at cycle 0 gives done at cycle WIDTH+2 (34). Divide-by-zero gives done at cycle 1.
- Overflow case: -2^31 / -1 gives lo=32'h80000000, hi=0; the magnitude wraps naturally and no flag is raised.
- start while busy=1: ignored, with no queueing.
- mthi/mtlo:
  - Take effect on the next edge only when busy=0 and start=0.
  - Ignored when busy=1.
  - If start and mthi/mtlo are asserted in the same cycle, start wins.
- hi/lo are stable except on reset, mthi/mtlo, or DONE entry.

Optional Feature:
- Macro: MULT_DIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the 64-bit product combinationally at start, using a signed or unsigned multiply per op.
  - IDLE goes to DONE, so done arrives at cycle 1. The MUL state and the shift-add datapath are omitted.
  - Divide behaviour is unchanged.
- Undefined: iterative multiply as described in Behaviour.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum IDLE/MUL/DIV/FIX/DONE.
  - WIDTH default.
  - localparam DIV0_LO = 32'hFFFFFFFF.
- One sub-module, div_core: unsigned restoring divider step.
  - Takes remainder, quotient and divisor registers plus a step enable.
  - Produces the next remainder and quotient.
  - Instantiated once; the top level owns sign fix-up, the FSM and HI/LO.

Test Plan:
- MULTU 32'hFFFFFFFF * 32'hFFFFFFFF -> done at cycle 34; hi=32'hFFFFFFFE, lo=32'h00000001; busy high for cycles 1-33.
- MULT -7 * 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV -7 / 2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU 100 / 7 -> lo=14, hi=2.
- DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0, div_by_zero=0.
- DIVU 5 / 0 -> done at cycle 1; hi=5, lo=32'hFFFFFFFF, div_by_zero=1.
  - A following MULTU 2*3 clears the flag and gives lo=6.
- mthi 32'hA5A5A5A5 while idle -> hi updates next edge.
- mtlo asserted during busy -> lo unchanged.
- reset asserted at cycle 10 of a DIV -> next edge shows hi=lo=0, busy=0, and no done pulse.
- start pulsed again at cycle 5 of a MULT -> ignored; the original result is delivered at cycle 34.
